vend_apb_cfg_master: RTL and testbench

- APB initiator that programs and reads back the vending machine's item configuration registers on the slave side of the APB config port.
- Accepts single read/write commands from a local controller (test sequencer or boot loader) and runs a full APB3 transfer: SETUP, then ACCESS, with pready wait states and a pslverr response.
- Returns read data and error status on a held response channel.
- Includes a bounded wait-state timeout so a hung slave cannot stall configuration.

---
 rtl/vend_apb_cfg_master_if.sv | 39 +++
 rtl/vend_apb_cfg_master.sv | 99 +++++++++
 tb/tb_vend_apb_cfg_master.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_apb_cfg_master_if.sv
// Command/response channel and APB3 bus bundle for the vending config master.
// The master modport is the initiator; the slave modport is everything around it.
interface vend_apb_cfg_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/vend_apb_cfg_master.sv
// APB3 initiator running one read/write config transfer per command, with a
// bounded wait-state timeout and a held response channel.
module vend_apb_cfg_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic                   pclk,
    input logic                   prst,
    vend_apb_cfg_master_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    // Value of the wait counter on the last ACCESS cycle allowed before abort.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        wait_cnt;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              tmo_q;
    logic              access_done;
    logic              access_tmo;

    always_comb begin
        access_done = (state == S_ACCESS) && bus.pready;
        access_tmo  = (state == S_ACCESS) && !bus.pready && (wait_cnt == WAIT_LAST);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.cmd_valid) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: if (access_done || access_tmo) state_nxt = S_RESP;
            S_RESP:   if (bus.rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        paddr_q  <= bus.cmd_addr;
                        pwrite_q <= bus.cmd_write;
                        pwdata_q <= bus.cmd_wdata;
                        wait_cnt <= '0;
                    end
                end
                S_ACCESS: begin
                    // pready on the final allowed cycle still completes normally.
                    if (bus.pready) begin
                        rdata_q <= (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
                        err_q   <= bus.pslverr;
                        tmo_q   <= 1'b0;
                    end else if (access_tmo) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        tmo_q   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // cmd_ready is gated by prst so nothing is accepted while reset is held.
    assign bus.cmd_ready   = (state == S_IDLE) && !prst;
    assign bus.psel        = (state == S_SETUP) || (state == S_ACCESS);
    assign bus.penable     = (state == S_ACCESS);
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = (state == S_RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = tmo_q;
endmodule

// File: tb/tb_vend_apb_cfg_master.sv
// Bench for vend_apb_cfg_master: APB slave model plus a transaction-level
// reference model of the expected response, latency and bus activity.
module tb_vend_apb_cfg_master;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic pclk = 1'b0;
    logic prst = 1'b1;

    vend_apb_cfg_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vend_apb_cfg_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk),
        .prst(prst),
        .bus (bus)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    logic [31:0] slv_mem [8];
    logic [31:0] ref_mem [8];

    // Observations of the last transfer
    int          r_lat, r_psel, r_pen;
    bit          r_hung, r_busbad, r_setupbad, r_unstable, r_rdy_busy, r_psel_in_resp, r_nodrop;
    logic [31:0] r_rdata;
    logic        r_err, r_tmo;

    // Expectations of the last modelled transfer
    int          e_acc, e_lat, e_psel;
    logic [31:0] e_rdata;
    logic        e_err, e_tmo;

    task automatic model(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                         input int waits, input logic err);
        e_tmo   = (waits >= TIMEOUT);
        e_acc   = e_tmo ? TIMEOUT : waits + 1;
        e_err   = e_tmo || err;
        e_rdata = (!wr && !e_err) ? ref_mem[a] : 32'h0;
        if (wr && !e_err) ref_mem[a] = wd;
        e_lat   = 2 + e_acc;
        e_psel  = 1 + e_acc;
    endtask

    // Issues one command from a negedge with the DUT idle, plays the APB slave,
    // and records what the bus and response channel did.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic err, input int hold, input bit keep_valid);
        int cyc  = 0;
        int acc  = 0;
        int rcyc = 0;
        bit fin  = 0;
        r_lat = -1; r_psel = 0; r_pen = 0;
        r_hung = 0; r_busbad = 0; r_setupbad = 0; r_unstable = 0;
        r_rdy_busy = 0; r_psel_in_resp = 0; r_nodrop = 0;
        r_rdata = 'x; r_err = 1'bx; r_tmo = 1'bx;
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
        bus.rsp_ready = 1'b0; bus.pready = 1'b0; bus.pslverr = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        if (keep_valid) begin
            bus.cmd_write = ~wr; bus.cmd_addr = ~addr; bus.cmd_wdata = ~wdata;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        while (!fin && cyc < 200) begin
            cyc++;
            if (bus.rsp_ready) begin
                if (bus.rsp_valid) r_nodrop = 1;
                fin = 1;
            end else begin
                if (bus.cmd_ready) r_rdy_busy = 1;
                if (bus.psel) begin
                    r_psel++;
                    if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wdata) r_busbad = 1;
                    if ((r_psel == 1) == (bus.penable == 1'b1)) r_setupbad = 1;
                end
                if (bus.penable) r_pen++;
                bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = $urandom();
                if (bus.psel && bus.penable) begin
                    acc++;
                    if (acc > waits) begin
                        bus.pready  = 1'b1;
                        bus.pslverr = err;
                        bus.prdata  = slv_mem[bus.paddr[2:0]];
                        if (wr && !err) slv_mem[addr[2:0]] = wdata;
                    end
                end
                if (bus.rsp_valid) begin
                    if (bus.psel) r_psel_in_resp = 1;
                    rcyc++;
                    if (rcyc == 1) begin
                        r_lat = cyc; r_rdata = bus.rsp_rdata; r_err = bus.rsp_err; r_tmo = bus.rsp_timeout;
                    end else if (bus.rsp_rdata !== r_rdata || bus.rsp_err !== r_err || bus.rsp_timeout !== r_tmo) begin
                        r_unstable = 1;
                    end
                    if (rcyc > hold) bus.rsp_ready = 1'b1;
                end
                @(negedge pclk);
            end
        end
        if (!fin) r_hung = 1;
        bus.rsp_ready = 1'b0; bus.cmd_valid = 1'b0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin slv_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h5; bus.cmd_wdata = 32'hA5A5A5A5;
        bus.rsp_ready = 1'b0; bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 32'h0;
        prst = 1'b1;
        repeat (3) @(negedge pclk);
        total++; if ({bus.psel, bus.penable, bus.pwrite, bus.cmd_ready} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000", {bus.psel, bus.penable, bus.pwrite, bus.cmd_ready}); end
        total++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b0) begin
            bad++; $display("FAIL reset_rsp got=%b want=000", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}); end
        total++; if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h want=0", bus.paddr, bus.pwdata, bus.rsp_rdata); end
        bus.cmd_valid = 1'b0;
        prst = 1'b0;
        @(negedge pclk);
        total++; if (bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0) begin
            bad++; $display("FAIL reset_release got=%b%b want=10", bus.cmd_ready, bus.psel); end
    endtask

    task automatic test_write();
        model(1'b1, 3'd0, 32'h00640096, 0, 1'b0);
        run_cmd(1'b1, 32'h0, 32'h00640096, 0, 1'b0, 0, 1'b0);
        total++; if (r_hung || r_lat !== 3) begin bad++; $display("FAIL write_lat got=%0d hung=%0d want=3", r_lat, r_hung); end
        total++; if (r_psel !== 2 || r_pen !== 1) begin bad++; $display("FAIL write_phases got=%0d/%0d want=2/1", r_psel, r_pen); end
        total++; if (r_busbad || r_setupbad) begin bad++; $display("FAIL write_bus got=%0d/%0d want=0/0", r_busbad, r_setupbad); end
        total++; if (r_err !== e_err || r_tmo !== e_tmo || r_rdata !== e_rdata) begin
            bad++; $display("FAIL write_rsp got=%b%b %h want=%b%b %h", r_err, r_tmo, r_rdata, e_err, e_tmo, e_rdata); end
    endtask

    task automatic test_read_wait();
        model(1'b0, 3'd0, 32'h12345678, 2, 1'b0);
        run_cmd(1'b0, 32'h0, 32'h12345678, 2, 1'b0, 0, 1'b0);
        total++; if (r_pen !== 3 || r_lat !== 5) begin bad++; $display("FAIL read_wait_len got=%0d/%0d want=3/5", r_pen, r_lat); end
        total++; if (r_rdata !== 32'h00640096 || r_rdata !== e_rdata) begin
            bad++; $display("FAIL read_wait_data got=%h want=%h", r_rdata, e_rdata); end
        total++; if (r_err !== 1'b0 || r_busbad) begin bad++; $display("FAIL read_wait_err got=%b/%0d want=0/0", r_err, r_busbad); end
    endtask

    task automatic test_slverr();
        model(1'b1, 3'd1, 32'h00320010, 0, 1'b1);
        run_cmd(1'b1, 32'h1, 32'h00320010, 0, 1'b1, 0, 1'b0);
        total++; if (r_err !== 1'b1 || r_tmo !== 1'b0 || r_rdata !== 32'h0) begin
            bad++; $display("FAIL slverr_rsp got=%b%b %h want=10 0", r_err, r_tmo, r_rdata); end
        model(1'b0, 3'd1, 32'h0, 1, 1'b0);
        run_cmd(1'b0, 32'h1, 32'h0, 1, 1'b0, 0, 1'b0);
        total++; if (r_rdata !== e_rdata || r_err !== 1'b0) begin
            bad++; $display("FAIL slverr_readback got=%h want=%h", r_rdata, e_rdata); end
    endtask

    task automatic test_timeout();
        model(1'b0, 3'd0, 32'h0, 1000, 1'b0);
        run_cmd(1'b0, 32'h0, 32'h0, 1000, 1'b0, 0, 1'b0);
        total++; if (r_hung || r_pen !== TIMEOUT || r_psel !== TIMEOUT + 1) begin
            bad++; $display("FAIL timeout_len got=%0d/%0d want=%0d/%0d", r_pen, r_psel, TIMEOUT, TIMEOUT + 1); end
        total++; if (r_err !== 1'b1 || r_tmo !== 1'b1 || r_rdata !== 32'h0 || r_lat !== e_lat) begin
            bad++; $display("FAIL timeout_rsp got=%b%b %h lat=%0d want=11 0 lat=%0d", r_err, r_tmo, r_rdata, r_lat, e_lat); end
        model(1'b0, 3'd0, 32'h0, TIMEOUT - 1, 1'b0);
        run_cmd(1'b0, 32'h0, 32'h0, TIMEOUT - 1, 1'b0, 0, 1'b0);
        total++; if (r_pen !== TIMEOUT || r_tmo !== 1'b0 || r_err !== 1'b0) begin
            bad++; $display("FAIL timeout_edge got=%0d %b%b want=%0d 00", r_pen, r_err, r_tmo, TIMEOUT); end
        total++; if (r_rdata !== 32'h00640096) begin bad++; $display("FAIL timeout_edge_data got=%h want=00640096", r_rdata); end
    endtask

    task automatic test_back_to_back();
        model(1'b1, 3'd2, 32'h000A0007, 0, 1'b0);
        run_cmd(1'b1, 32'h2, 32'h000A0007, 0, 1'b0, 5, 1'b1);
        total++; if (r_unstable || r_rdy_busy || r_psel_in_resp) begin
            bad++; $display("FAIL hold_rsp got=%0d%0d%0d want=000", r_unstable, r_rdy_busy, r_psel_in_resp); end
        total++; if (r_psel !== 2 || r_busbad || r_nodrop) begin
            bad++; $display("FAIL hold_bus got=%0d %0d %0d want=2 0 0", r_psel, r_busbad, r_nodrop); end
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL hold_idle got=%b want=1", bus.cmd_ready); end
        model(1'b0, 3'd2, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 32'h2, 32'h0, 0, 1'b0, 0, 1'b0);
        total++; if (r_rdata !== 32'h000A0007 || r_lat !== 3) begin
            bad++; $display("FAIL hold_next got=%h lat=%0d want=000a0007 lat=3", r_rdata, r_lat); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h3; bus.cmd_wdata = 32'h7F7F7F7F;
        bus.pready = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);
        total++; if ({bus.psel, bus.penable} !== 2'b11) begin bad++; $display("FAIL midrst_pre got=%b want=11", {bus.psel, bus.penable}); end
        #2 prst = 1'b1;
        #1;
        total++; if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.cmd_ready} !== 5'b0 || bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) begin
            bad++; $display("FAIL midrst_async got=%b %h %h want=0", {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.cmd_ready}, bus.paddr, bus.pwdata); end
        @(negedge pclk);
        prst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid || bus.psel) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL midrst_quiet got=1 want=0"); end
        model(1'b0, 3'd3, 32'h0, 1, 1'b0);
        run_cmd(1'b0, 32'h3, 32'h0, 1, 1'b0, 0, 1'b0);
        total++; if (r_hung || r_rdata !== e_rdata || r_err !== 1'b0 || r_lat !== e_lat) begin
            bad++; $display("FAIL midrst_next got=%h lat=%0d want=%h lat=%0d", r_rdata, r_lat, e_rdata, e_lat); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic        wr;
            logic [2:0]  a;
            logic [31:0] wd;
            int          waits, sel, hold;
            logic        err;
            wr   = 1'($urandom_range(0, 1));
            a    = 3'($urandom_range(0, 7));
            wd   = {9'b0, 7'($urandom_range(0, 127)), 16'($urandom())};
            sel  = $urandom_range(0, 9);
            waits = (sel == 0) ? TIMEOUT + $urandom_range(0, 3) : (sel == 1) ? TIMEOUT - 1 : $urandom_range(0, 3);
            err  = ($urandom_range(0, 5) == 0);
            hold = $urandom_range(0, 2);
            model(wr, a, wd, waits, err);
            run_cmd(wr, {29'b0, a}, wd, waits, err, hold, 1'b0);
            total++; if (r_hung || r_rdata !== e_rdata || r_err !== e_err || r_tmo !== e_tmo) begin
                bad++; $display("FAIL rand%0d_rsp got=%h %b%b want=%h %b%b", n, r_rdata, r_err, r_tmo, e_rdata, e_err, e_tmo); end
            total++; if (r_lat !== e_lat || r_pen !== e_acc || r_psel !== e_psel || r_busbad || r_setupbad || r_unstable) begin
                bad++; $display("FAIL rand%0d_bus got=%0d/%0d/%0d want=%0d/%0d/%0d", n, r_lat, r_pen, r_psel, e_lat, e_acc, e_psel); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=expired want=finished");
        $fatal(1, "watchdog");
    end
endmodule
